// File: rtl/phy_rst_seq.sv
// phy_rst_seq: Ethernet PHY reset/bring-up sequencer with link-up wait and bounded retries.
// Status outputs are registered from the next-state decode so they track the state register.
module phy_rst_seq #(
    parameter int ASSERT_CYCLES = 250000,
    parameter int WAIT_CYCLES   = 50000,
    parameter int LINK_TIMEOUT  = 2500000,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 22,
    parameter int RETRY_W       = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic               link_up_i,
    output logic               phy_rst_no,
    output logic               busy_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retries_o
);
    localparam logic [2:0] S_ASSERT = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_LINK   = 3'd2;
    localparam logic [2:0] S_READY  = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    localparam logic [CNT_W-1:0]   ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LINK_LAST   = CNT_W'(LINK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    logic [2:0]         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
    logic [RETRY_W-1:0] retry, retry_nx;

    // Saturating increment keeps the unbounded link wait from wrapping.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_inc;
        retry_nx = retry;
        case (state)
            S_ASSERT: begin
                if (cnt == ASSERT_LAST) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
                end
            end
            S_WAIT: begin
                if (req_i) begin
                    state_nx = S_ASSERT;
                    cnt_nx   = '0;
                    retry_nx = '0;
                end else if (cnt == WAIT_LAST) begin
                    state_nx = S_LINK;
                    cnt_nx   = '0;
                end
            end
            S_LINK: begin
                if (req_i) begin
                    state_nx = S_ASSERT;
                    cnt_nx   = '0;
                    retry_nx = '0;
                end else if (link_up_i) begin
                    state_nx = S_READY;
                    cnt_nx   = '0;
                end else if (LINK_TIMEOUT != 0 && cnt == LINK_LAST) begin
                    cnt_nx   = '0;
                    state_nx = (retry < RETRY_MAX) ? S_ASSERT : S_FAIL;
                    retry_nx = (retry < RETRY_MAX) ? retry + 1'b1 : retry;
                end
            end
            S_READY, S_FAIL: begin
                cnt_nx = '0;
                if (req_i) begin
                    state_nx = S_ASSERT;
                    retry_nx = '0;
                end
            end
            default: begin
                state_nx = S_ASSERT;
                cnt_nx   = '0;
                retry_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= S_ASSERT;
            cnt        <= '0;
            retry      <= '0;
            phy_rst_no <= 1'b0;
            busy_o     <= 1'b1;
            ready_o    <= 1'b0;
            fail_o     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            retry      <= retry_nx;
            phy_rst_no <= state_nx != S_ASSERT;
            busy_o     <= state_nx == S_ASSERT || state_nx == S_WAIT || state_nx == S_LINK;
            ready_o    <= state_nx == S_READY;
            fail_o     <= state_nx == S_FAIL;
        end
    end

    assign retries_o = retry;
endmodule
